mult_scheduler: RTL and testbench

- Sequences the shared 8-bit signed add-shift multiplier datapath (X/A/B registers, add_sub, control strobes).
- Arbitrates that datapath between two requesters.
- Each requester submits a multiplicand/multiplier pair over a valid/ready handshake. The block drives the datapath control strobes and the shared S operand bus for the full multiply, then returns the 16-bit product with a requester ID.
- Replaces direct switch/button sequencing when the multiplier is shared by on-chip clients.

---
 rtl/mult_sched_pkg.sv | 6 +
 rtl/mult_scheduler_rr_arb2.sv | 12 +
 rtl/mult_scheduler.sv | 123 ++++++++++++
 tb/tb_mult_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared sizing and state encoding for the multiplier scheduler.
package mult_sched_pkg;
    localparam int SCHED_WIDTH = 8;
    localparam int CNT_W = $clog2(SCHED_WIDTH);
    typedef enum logic [2:0] {IDLE, LOADB, ADD, SHIFT, DONE} sched_state_t;
endpackage

// File: rtl/mult_scheduler_rr_arb2.sv
// rr_arb2: combinational two-way arbiter, round-robin or fixed priority to requester 0.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    input  logic       i_rr_en,
    output logic       o_gnt_valid,
    output logic       o_gnt_idx
);
    assign o_gnt_valid = |i_req;
    // On a tie the requester that lost last time goes first; fixed mode always favours 0
    assign o_gnt_idx = &i_req ? (i_rr_en & ~i_last_grant) : i_req[1];
endmodule

// File: rtl/mult_scheduler.sv
// mult_scheduler: arbitrates two requesters onto the shared add-shift signed multiplier
// datapath and sequences its strobes for one full multiply per accepted request.
module mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter int WIDTH = SCHED_WIDTH,
    parameter bit RR_EN = 1'b1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0][WIDTH-1:0]     req_mcand,
    input  logic [1:0][WIDTH-1:0]     req_mplier,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_id,
    output logic [2*WIDTH-1:0]        rsp_product,
    output logic [WIDTH-1:0]          S,
    output logic                      Clear_XA,
    output logic                      Clear_B,
    output logic                      Load_XA,
    output logic                      Load_B,
    output logic                      Shift,
    output logic                      Sub,
    input  logic                      M,
    input  logic [WIDTH-1:0]          Aval,
    input  logic [WIDTH-1:0]          Bval
);
    sched_state_t     r_state, w_next;
    logic [WIDTH-1:0] r_mcand, r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic             r_id, r_last_grant;
    logic             w_gnt_valid, w_gnt_idx, w_last_iter, w_accept;

    rr_arb2 u_arb (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .i_rr_en      (RR_EN),
        .o_gnt_valid  (w_gnt_valid),
        .o_gnt_idx    (w_gnt_idx)
    );

    assign w_last_iter = r_cnt == CNT_W'(WIDTH - 1);
    assign w_accept    = r_state == IDLE && w_gnt_valid;
    assign rsp_product = {Aval, Bval};
    assign rsp_id      = r_id;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_cnt        <= '0;
            r_mcand      <= '0;
            r_mplier     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mcand      <= req_mcand[w_gnt_idx];
                r_mplier     <= req_mplier[w_gnt_idx];
                r_id         <= w_gnt_idx;
                r_last_grant <= w_gnt_idx;
            end
            if (r_state == LOADB)
                r_cnt <= '0;
            else if (r_state == SHIFT && !w_last_iter)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        rsp_valid = 1'b0;
        S         = r_mcand;
        Clear_XA  = 1'b0;
        Clear_B   = 1'b0;
        Load_XA   = 1'b0;
        Load_B    = 1'b0;
        Shift     = 1'b0;
        Sub       = 1'b0;
        case (r_state)
            IDLE: if (w_gnt_valid) begin
                req_ready[w_gnt_idx] = 1'b1;
                w_next               = LOADB;
            end
            LOADB: begin
                S        = r_mplier;
                Load_B   = 1'b1;
                Clear_XA = 1'b1;
                w_next   = ADD;
            end
            // The final partial product carries the multiplier sign bit, so it is subtracted
            ADD: begin
                Load_XA = M;
                Sub     = w_last_iter;
                w_next  = SHIFT;
            end
            SHIFT: begin
                Shift  = 1'b1;
                w_next = w_last_iter ? DONE : ADD;
            end
            DONE: begin
                rsp_valid = 1'b1;
                w_next    = rsp_ready ? IDLE : DONE;
            end
            default: w_next = IDLE;
        endcase
        if (Reset) begin
            w_next    = IDLE;
            req_ready = '0;
            rsp_valid = 1'b0;
            S         = '0;
            Clear_XA  = 1'b1;
            Clear_B   = 1'b1;
            Load_XA   = 1'b0;
            Load_B    = 1'b0;
            Shift     = 1'b0;
            Sub       = 1'b0;
        end
    end
endmodule

// File: tb/tb_mult_scheduler.sv
// tb_mult_scheduler: scoreboard bench driving two schedulers (round-robin and fixed
// priority), each with its own behavioural X/A/B add-shift datapath.
module tb_mult_scheduler;
    typedef struct packed {
        logic        id;
        logic [15:0] prod;
        int          t;
    } exp_t;

    logic            clk = 1'b0, rst = 1'b1, rsp_ready = 1'b1;
    logic [1:0]      req_valid = '0;
    logic [1:0][7:0] mcand = '0, mplier = '0;
    int              cyc = 0, checks = 0, errors = 0;
    exp_t            sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [1:0]  req_ready;
        logic        rsp_valid, rsp_id, cxa, cb, lxa, lb, sh, sub, x_q;
        logic [15:0] prod;
        logic [7:0]  s, a_q, b_q;
        logic [8:0]  sum;
        int          lxa_cnt = 0, strobe_cnt = 0;

        mult_scheduler #(.WIDTH(8), .RR_EN(k == 0)) u_dut (
            .Clk(clk), .Reset(rst), .req_valid(req_valid), .req_ready(req_ready),
            .req_mcand(mcand), .req_mplier(mplier), .rsp_valid(rsp_valid),
            .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_product(prod), .S(s),
            .Clear_XA(cxa), .Clear_B(cb), .Load_XA(lxa), .Load_B(lb), .Shift(sh),
            .Sub(sub), .M(b_q[0]), .Aval(a_q), .Bval(b_q)
        );

        assign sum = sub ? {a_q[7], a_q} - {s[7], s} : {a_q[7], a_q} + {s[7], s};

        always @(posedge clk) begin
            if (cxa) begin
                x_q <= 1'b0;
                a_q <= '0;
            end else if (lxa) begin
                x_q <= sum[8];
                a_q <= sum[7:0];
            end else if (sh) a_q <= {x_q, a_q[7:1]};
            if (cb) b_q <= '0;
            else if (lb) b_q <= s;
            else if (sh) b_q <= {a_q[0], b_q[7:1]};
            lxa_cnt    <= lxa_cnt + int'(lxa);
            strobe_cnt <= strobe_cnt + int'(|{cxa, cb, lxa, lb, sh, sub});
        end

        always @(negedge clk) begin
            assert ($onehot0({lxa, lb, sh}))
                else $error("FAIL strobe_excl dut%0d cyc %0d got %b", k, cyc, {lxa, lb, sh});
            assert ($onehot0(req_ready))
                else $error("FAIL ready_onehot dut%0d cyc %0d got %b", k, cyc, req_ready);
        end
    end

    task automatic hs_wait(input logic [1:0] mask, output bit ok);
        logic signed [15:0] p;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            for (int r = 0; r < 2; r++)
                if (mask[r] && req_valid[r] && g_dut[0].req_ready[r]) begin
                    p = $signed(mcand[r]) * $signed(mplier[r]);
                    sbq.push_back('{id: 1'(r), prod: p, t: cyc});
                    ok = 1'b1;
                end
            if (!ok) @(negedge clk);
        end
    endtask

    task automatic rsp_wait(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            ok = g_dut[0].rsp_valid;
            if (!ok) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks += 3;
        if ({g_dut[0].cxa, g_dut[0].cb, g_dut[0].lxa, g_dut[0].lb, g_dut[0].sh, g_dut[0].sub,
             g_dut[0].rsp_valid} !== 7'b1100000) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 1100000", {g_dut[0].cxa, g_dut[0].cb,
                     g_dut[0].lxa, g_dut[0].lb, g_dut[0].sh, g_dut[0].sub, g_dut[0].rsp_valid});
        end
        if (g_dut[0].req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready got %b exp 00", g_dut[0].req_ready);
        end
        if (g_dut[0].s !== 8'h00) begin
            errors++;
            $display("FAIL reset_s got %h exp 00", g_dut[0].s);
        end
        rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if ({g_dut[0].cxa, g_dut[0].cb, g_dut[0].lxa, g_dut[0].lb, g_dut[0].sh, g_dut[0].sub,
             g_dut[0].rsp_valid, g_dut[0].req_ready} !== 9'b0) begin
            errors++;
            $display("FAIL idle_outputs got %b exp 0", {g_dut[0].cxa, g_dut[0].cb, g_dut[0].lxa,
                     g_dut[0].lb, g_dut[0].sh, g_dut[0].sub, g_dut[0].rsp_valid, g_dut[0].req_ready});
        end
        if (g_dut[0].s !== 8'h00) begin
            errors++;
            $display("FAIL idle_s got %h exp 00", g_dut[0].s);
        end
    endtask

    task automatic test_basic();
        bit         ids[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] av[6]  = '{8'h07, 8'h80, 8'h7F, 8'h00, 8'hA5, 8'h80};
        logic [7:0] bv[6]  = '{8'hFD, 8'h80, 8'h7F, 8'hA5, 8'h00, 8'h7F};
        bit   ok;
        exp_t e;
        int   l0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mcand[ids[i]]     = av[i];
            mplier[ids[i]]    = bv[i];
            req_valid[ids[i]] = 1'b1;
            l0 = g_dut[0].lxa_cnt;
            hs_wait(2'b11, ok);
            @(negedge clk);
            req_valid = '0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL basic_handshake vec %0d got none exp req_ready[%0d]", i, ids[i]);
                continue;
            end
            rsp_wait(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL basic_rsp vec %0d got no rsp_valid exp rsp_valid", i);
                void'(sbq.pop_front());
                continue;
            end
            e = sbq.pop_front();
            checks += 4;
            if (g_dut[0].prod !== e.prod) begin
                errors++;
                $display("FAIL basic_prod vec %0d got %h exp %h", i, g_dut[0].prod, e.prod);
            end
            if (g_dut[0].rsp_id !== e.id) begin
                errors++;
                $display("FAIL basic_id vec %0d got %0d exp %0d", i, g_dut[0].rsp_id, e.id);
            end
            if (cyc - e.t != 18) begin
                errors++;
                $display("FAIL basic_latency vec %0d got %0d exp 18", i, cyc - e.t);
            end
            if (g_dut[0].lxa_cnt - l0 != $countones(bv[i])) begin
                errors++;
                $display("FAIL basic_load_xa vec %0d got %0d exp %0d", i, g_dut[0].lxa_cnt - l0,
                         $countones(bv[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit                 ok;
        exp_t               e;
        logic signed [15:0] p1;
        @(negedge clk);
        rst       = 1'b1;
        mcand     = {8'hC5, 8'h11};
        mplier    = {8'h3A, 8'hF3};
        req_valid = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hs_wait(2'b11, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL b2b_handshake iter %0d got none exp grant", i);
                break;
            end
            p1 = $signed(mcand[0]) * $signed(mplier[0]);
            checks += 2;
            if (sbq[$].id !== 1'(i % 2)) begin
                errors++;
                $display("FAIL b2b_grant iter %0d got %0d exp %0d", i, sbq[$].id, i % 2);
            end
            if (g_dut[1].req_ready !== 2'b01) begin
                errors++;
                $display("FAIL fixed_grant iter %0d got %b exp 01", i, g_dut[1].req_ready);
            end
            @(negedge clk);
            mcand[sbq[$].id]  = mcand[sbq[$].id] + 8'h1D;
            mplier[sbq[$].id] = mplier[sbq[$].id] ^ 8'h5B;
            if (i == 3) req_valid = '0;
            rsp_wait(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL b2b_rsp iter %0d got no rsp_valid exp rsp_valid", i);
                break;
            end
            e = sbq.pop_front();
            checks += 3;
            if ({g_dut[0].rsp_id, g_dut[0].prod} !== {e.id, e.prod}) begin
                errors++;
                $display("FAIL b2b_rsp iter %0d got id %0d %h exp id %0d %h", i, g_dut[0].rsp_id,
                         g_dut[0].prod, e.id, e.prod);
            end
            if (cyc - e.t != 18) begin
                errors++;
                $display("FAIL b2b_latency iter %0d got %0d exp 18", i, cyc - e.t);
            end
            if ({g_dut[1].rsp_valid, g_dut[1].rsp_id, g_dut[1].prod} !== {2'b10, p1}) begin
                errors++;
                $display("FAIL fixed_rsp iter %0d got v%0d id %0d %h exp v1 id 0 %h", i,
                         g_dut[1].rsp_valid, g_dut[1].rsp_id, g_dut[1].prod, p1);
            end
        end
        req_valid = '0;
        sbq.delete();
    endtask

    task automatic test_stall();
        bit   ok;
        exp_t e;
        int   s0, rel;
        @(negedge clk);
        rsp_ready = 1'b0;
        mcand[0]  = 8'h5A;
        mplier[0] = 8'hC3;
        req_valid = 2'b01;
        hs_wait(2'b01, ok);
        @(negedge clk);
        req_valid = '0;
        rsp_wait(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_rsp got no rsp_valid exp rsp_valid");
            rsp_ready = 1'b1;
            sbq.delete();
            return;
        end
        e  = sbq.pop_front();
        s0 = g_dut[0].strobe_cnt;
        mcand[1]  = 8'hE7;
        mplier[1] = 8'h64;
        req_valid = 2'b10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks += 2;
            if ({g_dut[0].rsp_valid, g_dut[0].rsp_id, g_dut[0].prod} !== {2'b10, e.prod}) begin
                errors++;
                $display("FAIL stall_hold cyc %0d got v%0d id %0d %h exp v1 id 0 %h", i,
                         g_dut[0].rsp_valid, g_dut[0].rsp_id, g_dut[0].prod, e.prod);
            end
            if (g_dut[0].req_ready !== 2'b00) begin
                errors++;
                $display("FAIL stall_ready cyc %0d got %b exp 00", i, g_dut[0].req_ready);
            end
        end
        checks++;
        if (g_dut[0].strobe_cnt != s0) begin
            errors++;
            $display("FAIL stall_strobes got %0d exp 0", g_dut[0].strobe_cnt - s0);
        end
        rsp_ready = 1'b1;
        rel = cyc;
        hs_wait(2'b10, ok);
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (!ok || sbq[$].t != rel + 1) begin
            errors++;
            $display("FAIL stall_next_grant got cycle %0d exp %0d", ok ? sbq[$].t : -1, rel + 1);
            sbq.delete();
            return;
        end
        rsp_wait(ok);
        e = sbq.pop_front();
        checks++;
        if (!ok || {g_dut[0].rsp_id, g_dut[0].prod} !== {e.id, e.prod} || cyc - e.t != 18) begin
            errors++;
            $display("FAIL stall_second got id %0d %h lat %0d exp id %0d %h lat 18",
                     g_dut[0].rsp_id, g_dut[0].prod, cyc - e.t, e.id, e.prod);
        end
    endtask

    task automatic test_reset_mid();
        bit   ok;
        exp_t e;
        int   n = 0, rel;
        @(negedge clk);
        mcand[0]  = 8'h33;
        mplier[0] = 8'h9C;
        req_valid = 2'b01;
        hs_wait(2'b01, ok);
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < 40 && n < 5; i++) begin
            if (g_dut[0].sh) n++;
            if (n < 5) @(negedge clk);
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL midrst_shift_count got %0d exp 5", n);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({g_dut[0].cxa, g_dut[0].cb, g_dut[0].lxa, g_dut[0].lb, g_dut[0].sh, g_dut[0].sub,
             g_dut[0].rsp_valid} !== 7'b1100000) begin
            errors++;
            $display("FAIL midrst_strobes got %b exp 1100000", {g_dut[0].cxa, g_dut[0].cb,
                     g_dut[0].lxa, g_dut[0].lb, g_dut[0].sh, g_dut[0].sub, g_dut[0].rsp_valid});
        end
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        mcand[1]  = 8'hE0;
        mplier[1] = 8'h19;
        req_valid = 2'b10;
        rel = cyc;
        hs_wait(2'b10, ok);
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (!ok || sbq[$].t != rel) begin
            errors++;
            $display("FAIL midrst_idle got grant cycle %0d exp %0d", ok ? sbq[$].t : -1, rel);
            sbq.delete();
            return;
        end
        rsp_wait(ok);
        e = sbq.pop_front();
        checks++;
        if (!ok || {g_dut[0].rsp_id, g_dut[0].prod} !== {e.id, e.prod} || cyc - e.t != 18) begin
            errors++;
            $display("FAIL midrst_next got id %0d %h lat %0d exp id %0d %h lat 18",
                     g_dut[0].rsp_id, g_dut[0].prod, cyc - e.t, e.id, e.prod);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
